// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package tx_sched_pkg;

  // Scheduler FSM states; IDLE must encode as zero.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARM       = 2'b01,
    WAIT_DONE = 2'b10,
    GAP       = 2'b11
  } state_t;

  // Value tx_byte holds when nothing has been loaded since reset.
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  // State entered when a frame finishes (done or timeout).
  function automatic state_t frame_end_state(input int gap_cycles);
    return (gap_cycles > 0) ? GAP : IDLE;
  endfunction

endpackage

// File: rtl/tx_sched_rr_arbiter.sv
// Rotating-priority picker: the first set request searching upward
// from ptr+1 (wrapping at N_REQ) wins. Purely combinational.
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    winner
);

  // Scan the N_REQ positions after ptr and keep the first hit.
  always_comb begin
    int idx;
    idx    = 0;
    any    = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Transmit scheduler: shares one UART byte transmitter between several
// byte producers. Round-robin pick, byte latch, start pulse, completion
// wait with timeout, then an inter-frame guard gap.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ack,
  input  logic                     tx_ready,
  input  logic                     tx_done,
  output logic                     tx_ctrl,
  output logic [7:0]               tx_byte,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     tx_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  // Counter value in the last WAIT_DONE cycle before a timeout fires.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);
  localparam state_t FRAME_END        = frame_end_state(GAP_CYCLES);

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     win;
  logic              any;
  logic [TW-1:0]     to_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              load;
  logic              start;
  logic              expire;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .any    (any),
    .winner (win)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and one-cycle strobes for the datapath.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    start    = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          load     = 1'b1;
          state_nx = ARM;
        end
      end
      ARM: begin
        if (tx_ready) begin
          start    = 1'b1;
          state_nx = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // tx_done coinciding with our own start pulse belongs to no frame of ours.
        if (tx_done && !tx_ctrl) begin
          state_nx = FRAME_END;
        end else if (to_cnt == TO_LAST) begin
          expire   = 1'b1;
          state_nx = FRAME_END;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Grant, byte latch and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      req_ack  <= '0;
      tx_ctrl  <= 1'b0;
      tx_err   <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= IW'(N_REQ - 1);
      tx_byte  <= IDLE_BYTE;
    end else begin
      req_ack <= load ? (ONE << win) : '0;
      tx_ctrl <= start;
      tx_err  <= expire;
      busy    <= (state_nx != IDLE);
      if (load) begin
        tx_byte  <= req_data[8*win +: 8];
        grant_id <= win;
        rr_ptr   <= win;
      end
    end
  end

  // Completion timeout counter: cleared on start, counts through WAIT_DONE.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      to_cnt <= '0;
    end else if (start) begin
      to_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Guard-gap counter: loads on GAP entry, counts down to zero.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      gap_cnt <= '0;
    end else if ((state != GAP) && (state_nx == GAP)) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule
